// File: rtl/array_column_packer.sv
// ============================================================================
// Module   : array_column_packer
// Brief    : Gathers BIT_WIDTH-bit elements one per handshake into a flat
//            COLS*BIT_WIDTH word (column 0 at LSBs), valid/ready both sides.
//            Optional partial-word flush: define ARRAY_COLUMN_PACKER_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module array_column_packer #(
    parameter int BIT_WIDTH = 4,
    parameter int COLS      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
`ifdef ARRAY_COLUMN_PACKER_FLUSH_EN
    input  logic                          flush,
    output logic [$clog2(COLS+1)-1:0]     out_cols,
`endif
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIT_WIDTH-1:0]          in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COLS*BIT_WIDTH-1:0]     out_data,
    output logic [$clog2(COLS+1)-1:0]     fill_count
);

    localparam int CW = $clog2(COLS + 1);
    localparam int DW = COLS * BIT_WIDTH;

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic [DW-1:0]   r_data;
    logic [DW-1:0]   w_data_nxt;
    logic            w_accept;
    logic            w_emit;

    // in_ready only follows out_ready while a finished word is waiting
    assign in_ready   = (r_state == S_FILL) || out_ready;
    assign out_valid  = (r_state == S_FULL);
    assign out_data   = r_data;
    assign fill_count = r_count;
    assign w_accept   = in_valid && in_ready;
    assign w_emit     = out_valid && out_ready;

`ifdef ARRAY_COLUMN_PACKER_FLUSH_EN
    assign out_cols = out_valid ? r_count : '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_data_nxt  = r_data;
        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    for (int i = 0; i < COLS; i++) begin
                        if (r_count == CW'(i)) begin
                            w_data_nxt[i*BIT_WIDTH +: BIT_WIDTH] = in_data;
                        end
                    end
                    w_count_nxt = r_count + 1'b1;
                    if (r_count == CW'(COLS - 1)) begin
                        w_state_nxt = S_FULL;
                    end
                end
`ifdef ARRAY_COLUMN_PACKER_FLUSH_EN
                else if (flush && (r_count != '0)) begin
                    // Unwritten columns are already zero; count keeps the partial size
                    w_state_nxt = S_FULL;
                end
`endif
            end
            S_FULL: begin
                if (w_emit) begin
                    w_data_nxt  = '0;
                    w_count_nxt = '0;
                    w_state_nxt = S_FILL;
                    if (w_accept) begin
                        // New element starts the next word in column 0
                        w_data_nxt[BIT_WIDTH-1:0] = in_data;
                        w_count_nxt               = CW'(1);
                        if (COLS == 1) begin
                            w_state_nxt = S_FULL;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
            r_count <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_data  <= w_data_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_array_column_packer.sv
// ============================================================================
// Module   : tb_array_column_packer
// Brief    : Self-checking bench for array_column_packer (BIT_WIDTH=4, COLS=8)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_array_column_packer;

    localparam int BW   = 4;
    localparam int COLS = 8;
    localparam int CW   = $clog2(COLS + 1);
    localparam int DW   = COLS * BW;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] fill_count;
`ifdef ARRAY_COLUMN_PACKER_FLUSH_EN
    logic          flush;
    logic [CW-1:0] out_cols;
`endif

    array_column_packer #(.BIT_WIDTH(BW), .COLS(COLS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef ARRAY_COLUMN_PACKER_FLUSH_EN
        .flush      (flush),
        .out_cols   (out_cols),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fill_count (fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] m_word;
    int            m_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: assemble words from accepted elements
    task automatic model_accept(input logic [BW-1:0] d);
        m_word[m_cnt*BW +: BW] = d;
        m_cnt++;
        if (m_cnt == COLS) begin
            sb_q.push_back(m_word);
            m_word = '0;
            m_cnt  = 0;
        end
    endtask

    task automatic model_clear();
        m_word = '0;
        m_cnt  = 0;
    endtask

    task automatic send(input logic [BW-1:0] d);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", 64'(ok), 64'd1);
        if (ok) model_accept(d);
        @(posedge clk);
        #1;
    endtask

    // Output side of the scoreboard
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [DW-1:0] exp_w;
            if (sb_q.size() != 0) exp_w = sb_q.pop_front();
            else                  exp_w = 'x;
            check("word", 64'(out_data), 64'(exp_w));
        end
    end

    initial begin
        int c0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef ARRAY_COLUMN_PACKER_FLUSH_EN
        flush     = 1'b0;
`endif
        model_clear();

        #3;
        check("rst_out_valid",  64'(out_valid),  64'd0);
        check("rst_in_ready",   64'(in_ready),   64'd1);
        check("rst_fill_count", 64'(fill_count), 64'd0);
        check("rst_out_data",   64'(out_data),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word with the consumer stalled
        for (int i = 1; i <= 8; i++) send(BW'(i));
        in_valid = 1'b0;
        check("single_out_valid",  64'(out_valid),  64'd1);
        check("single_out_data",   64'(out_data),   64'h87654321);
        check("single_in_ready",   64'(in_ready),   64'd0);
        check("single_fill_count", 64'(fill_count), 64'd8);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_out_data",  64'(out_data),  64'h87654321);
            check("stall_out_valid", 64'(out_valid), 64'd1);
        end

        // Release with a simultaneous accept
        out_ready = 1'b1;
        send(4'hA);
        in_valid = 1'b0;
        check("release_fill_count", 64'(fill_count), 64'd1);
        check("release_out_data",   64'(out_data),   64'h0000000A);
        check("release_out_valid",  64'(out_valid),  64'd0);

        // Reset mid-word
        send(4'hB);
        send(4'hC);
        in_valid = 1'b0;
        check("mid_fill_count", 64'(fill_count), 64'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_fill_count", 64'(fill_count), 64'd0);
        check("mid_rst_out_valid",  64'(out_valid),  64'd0);
        check("mid_rst_in_ready",   64'(in_ready),   64'd1);
        check("mid_rst_out_data",   64'(out_data),   64'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming 0..F with no bubbles
        c0 = cyc;
        for (int i = 0; i < 16; i++) send(BW'(i));
        in_valid = 1'b0;
        check("stream_cycles", 64'(cyc - c0), 64'd16);
        for (int k = 0; k < 10; k++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        check("stream_drain",      64'(sb_q.size()), 64'd0);
        check("stream_out_valid",  64'(out_valid),   64'd0);
        check("stream_fill_count", 64'(fill_count),  64'd0);

`ifdef ARRAY_COLUMN_PACKER_FLUSH_EN
        out_ready = 1'b0;
        send(4'h5);
        send(4'h6);
        send(4'h7);
        in_valid = 1'b0;
        flush    = 1'b1;
        sb_q.push_back(m_word);
        model_clear();
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_out_valid",  64'(out_valid),  64'd1);
        check("flush_out_data",   64'(out_data),   64'h00000765);
        check("flush_out_cols",   64'(out_cols),   64'd3);
        check("flush_fill_count", 64'(fill_count), 64'd3);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("flush_emit_out_valid", 64'(out_valid), 64'd0);
        check("flush_emit_out_cols",  64'(out_cols),  64'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_empty_out_valid",  64'(out_valid),  64'd0);
        check("flush_empty_fill_count", 64'(fill_count), 64'd0);
`endif

        check("final_sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
